// File: rtl/id_pkg.sv
// Shared types and field positions for the ID stage: control bundle, ALU op codes,
// default register indices and A64 instruction field locations.
package id_pkg;

    localparam int DW_DEF       = 64;
    localparam int NREGS_DEF    = 32;
    localparam int ZR_IDX_DEF   = 31;
    localparam int LINK_IDX_DEF = 30;

    localparam int REG_FW    = 5;
    localparam int RD_LSB    = 0;
    localparam int RN_LSB    = 5;
    localparam int RM_LSB    = 16;
    localparam int IMM12_LSB = 10;
    localparam int IMM12_W   = 12;
    localparam int IMM9_LSB  = 12;
    localparam int IMM9_W    = 9;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_ORR    = 3'd3,
        ALU_PASS_B = 3'd4,
        ALU_LSL    = 3'd5,
        ALU_LSR    = 3'd6,
        ALU_XOR    = 3'd7
    } aluop_e;

    typedef struct packed {
        logic   reg2loc;
        logic   alusrc;
        logic   signext;
        logic   link;
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        aluop_e aluop;
    } ctl_t;

endpackage

// File: rtl/id_hazard_unit.sv
// Operand resolution (zero reg, EX forward, WB bypass, reg file) and RAW interlock.
// ID_FWD_EN enables EX-stage forwarding; without it any live EX-stage match interlocks.
module id_hazard_unit
    import id_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int ZR_IDX = ZR_IDX_DEF,
    parameter int RAW    = $clog2(NREGS)
) (
    input  logic [RAW-1:0] raddr1,
    input  logic [RAW-1:0] raddr2,
    input  logic           use1,
    input  logic           use2,
    input  logic [DW-1:0]  rf_rdata1,
    input  logic [DW-1:0]  rf_rdata2,
    input  logic           ex_valid,
    input  logic           ex_fwd_we,
    input  logic [RAW-1:0] ex_fwd_addr,
    input  logic [DW-1:0]  ex_fwd_data,
    input  logic           ex_fwd_load,
    input  logic           wb_we,
    input  logic [RAW-1:0] wb_addr,
    input  logic [DW-1:0]  wb_data,
    output logic [DW-1:0]  rdata1,
    output logic [DW-1:0]  rdata2,
    output logic           stall
);

    logic [1:0][RAW-1:0] addr;
    logic [1:0][DW-1:0]  rf;
    logic [1:0][DW-1:0]  res;
    logic [1:0]          use_src;
    logic [1:0]          is_zr;
    logic [1:0]          hit_ex;
    logic [1:0]          hit_wb;

    assign addr[0]    = raddr1;
    assign addr[1]    = raddr2;
    assign rf[0]      = rf_rdata1;
    assign rf[1]      = rf_rdata2;
    assign use_src[0] = use1;
    assign use_src[1] = use2;
    assign rdata1     = res[0];
    assign rdata2     = res[1];

`ifndef ID_FWD_EN
    logic unused_ex_fwd;
    assign unused_ex_fwd = ^{ex_fwd_data, ex_fwd_load};
`endif

    always_comb begin
        res    = '0;
        is_zr  = '0;
        hit_ex = '0;
        hit_wb = '0;
        stall  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            // The zero register is never a hazard source nor a forward target.
            is_zr[k]  = (addr[k] == RAW'(ZR_IDX));
            hit_ex[k] = ex_fwd_we && (addr[k] == ex_fwd_addr) && !is_zr[k];
            hit_wb[k] = wb_we && (addr[k] == wb_addr) && !is_zr[k];
`ifdef ID_FWD_EN
            if (is_zr[k])       res[k] = '0;
            else if (hit_ex[k]) res[k] = ex_fwd_data;
            else if (hit_wb[k]) res[k] = wb_data;
            else                res[k] = rf[k];
            if (ex_valid && ex_fwd_load && hit_ex[k] && use_src[k]) stall = 1'b1;
`else
            if (is_zr[k])       res[k] = '0;
            else if (hit_wb[k]) res[k] = wb_data;
            else                res[k] = rf[k];
            if (ex_valid && hit_ex[k] && use_src[k]) stall = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined instruction-decode stage: register reads, operand select, hazard handling
// and the ID/EX register with valid/ready handshake. ID_FWD_EN enables EX forwarding.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int ZR_IDX   = ZR_IDX_DEF,
    parameter int LINK_IDX = LINK_IDX_DEF,
    parameter int RAW      = $clog2(NREGS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_valid,
    input  logic [31:0]    if_instr,
    input  logic [DW-1:0]  if_pc_next,
    output logic           id_ready,
    input  ctl_t           ctl_i,
    input  logic           flush,
    output logic [RAW-1:0] rf_raddr1,
    output logic [RAW-1:0] rf_raddr2,
    input  logic [DW-1:0]  rf_rdata1,
    input  logic [DW-1:0]  rf_rdata2,
    input  logic           ex_fwd_we,
    input  logic [RAW-1:0] ex_fwd_addr,
    input  logic [DW-1:0]  ex_fwd_data,
    input  logic           ex_fwd_load,
    input  logic           wb_we,
    input  logic [RAW-1:0] wb_addr,
    input  logic [DW-1:0]  wb_data,
    input  logic           ex_ready,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_op1,
    output logic [DW-1:0]  ex_op2,
    output logic [DW-1:0]  ex_store_data,
    output logic [RAW-1:0] ex_waddr,
    output logic [DW-1:0]  ex_link_data,
    output ctl_t           ex_ctl
);

    logic [RAW-1:0] rn, rm, rd;
    logic           use1, use2, stall, accept;
    logic [DW-1:0]  reg1, reg2, imm_se, imm_ze, op2;
    logic           unused_instr;

    assign unused_instr = ^if_instr[31:22];

    assign rn        = RAW'(if_instr[RN_LSB +: REG_FW]);
    assign rm        = RAW'(if_instr[RM_LSB +: REG_FW]);
    assign rd        = RAW'(if_instr[RD_LSB +: REG_FW]);
    assign rf_raddr1 = rn;
    assign rf_raddr2 = ctl_i.reg2loc ? rd : rm;

    // BL does not read Rn; an immediate ALU op without a store does not read reg2.
    assign use1 = !ctl_i.link;
    assign use2 = !(ctl_i.alusrc && !ctl_i.memwrite);

    id_hazard_unit #(
        .DW(DW), .NREGS(NREGS), .ZR_IDX(ZR_IDX), .RAW(RAW)
    ) u_hazard (
        .raddr1      (rf_raddr1),
        .raddr2      (rf_raddr2),
        .use1        (use1),
        .use2        (use2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .ex_valid    (ex_valid),
        .ex_fwd_we   (ex_fwd_we),
        .ex_fwd_addr (ex_fwd_addr),
        .ex_fwd_data (ex_fwd_data),
        .ex_fwd_load (ex_fwd_load),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rdata1      (reg1),
        .rdata2      (reg2),
        .stall       (stall)
    );

    assign imm_se = {{(DW-IMM9_W){if_instr[IMM9_LSB+IMM9_W-1]}}, if_instr[IMM9_LSB +: IMM9_W]};
    assign imm_ze = {{(DW-IMM12_W){1'b0}}, if_instr[IMM12_LSB +: IMM12_W]};
    assign op2    = ctl_i.alusrc ? (ctl_i.signext ? imm_se : imm_ze) : reg2;

    // A flushed instruction is discarded, so IF may advance even while EX is stalled.
    assign id_ready = flush || (ex_ready && !stall);
    assign accept   = if_valid && ex_ready && !stall && !flush;

    logic           valid_d, valid_q;
    logic [DW-1:0]  op1_d, op1_q, op2_d, op2_q, sd_d, sd_q, link_d, link_q;
    logic [RAW-1:0] waddr_d, waddr_q;
    ctl_t           ctl_d, ctl_q;

    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sd_d    = sd_q;
        link_d  = link_q;
        waddr_d = waddr_q;
        ctl_d   = ctl_q;
        if (ex_ready) begin
            valid_d = accept;
            op1_d   = reg1;
            op2_d   = op2;
            sd_d    = reg2;
            link_d  = if_pc_next;
            waddr_d = ctl_i.link ? RAW'(LINK_IDX) : rd;
            ctl_d   = ctl_i;
            // Bubbles must carry no architectural side effects.
            if (!accept) begin
                ctl_d.regwrite = 1'b0;
                ctl_d.memwrite = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            sd_q    <= '0;
            link_q  <= '0;
            waddr_q <= '0;
            ctl_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sd_q    <= sd_d;
            link_q  <= link_d;
            waddr_q <= waddr_d;
            ctl_q   <= ctl_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_op1        = op1_q;
    assign ex_op2        = op2_q;
    assign ex_store_data = sd_q;
    assign ex_link_data  = link_q;
    assign ex_waddr      = waddr_q;
    assign ex_ctl        = ctl_q;

endmodule
